// File: rtl/minibyte_bus_responder_if.sv
// ---------------------------------------------------------------------------
// minibyte_bus_responder_if
//   CPU-side bus of the minibyte responder.
//   addr_in  : 7-bit CPU address
//   we_in    : 1 = write cycle, 0 = read cycle
//   data_in  : write data
//   data_out : read data, 0x00 whenever data_oe is low
//   data_oe  : read data valid (read cycle to a mapped address)
//   master modport drives the address/control/write data; slave answers.
// ---------------------------------------------------------------------------
interface minibyte_bus_responder_if;
   logic [6:0] addr_in;
   logic       we_in;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_oe;

   modport master (
      output addr_in, we_in, data_in,
      input  data_out, data_oe
   );

   modport slave (
      input  addr_in, we_in, data_in,
      output data_out, data_oe
   );
endinterface

// File: rtl/minibyte_bus_responder.sv
// ---------------------------------------------------------------------------
// minibyte_bus_responder
//   Small memory-mapped peripheral: 32x8 RAM, GPIO output register,
//   synchronized GPIO input, 8-bit timer with compare/auto-reload and a
//   sticky match flag that can raise an interrupt.
//
//   clk_in   : system clock, rising edge
//   rst_in   : asynchronous active-high reset
//   bus      : CPU bus (slave modport), zero-wait-state reads
//   gpio_in  : asynchronous external inputs (2-flop synchronized)
//   gpio_out : GPIO_OUT register
//   irq_out  : STAT.match AND CTRL.irq_en, purely from registers
//
//   Map: 0x00-0x1F RAM, 0x60 GPIO_OUT, 0x61 GPIO_IN (ro), 0x62 TCNT,
//        0x63 TCMP, 0x64 CTRL[2:0] = {irq_en, auto_reload, enable},
//        0x65 STAT[0] = match, write-1-to-clear.
// ---------------------------------------------------------------------------
module minibyte_bus_responder (
   input  logic                           clk_in,
   input  logic                           rst_in,
   minibyte_bus_responder_if.slave        bus,
   input  logic [7:0]                     gpio_in,
   output logic [7:0]                     gpio_out,
   output logic                           irq_out
);

   localparam logic [6:0] ADDR_GPIO_OUT = 7'h60;
   localparam logic [6:0] ADDR_GPIO_IN  = 7'h61;
   localparam logic [6:0] ADDR_TCNT     = 7'h62;
   localparam logic [6:0] ADDR_TCMP     = 7'h63;
   localparam logic [6:0] ADDR_CTRL     = 7'h64;
   localparam logic [6:0] ADDR_STAT     = 7'h65;

   logic [7:0] ram_q [32];
   logic [7:0] gpio_out_q, gpio_out_d;
   logic [7:0] sync1_q, sync2_q;
   logic [7:0] tcnt_q, tcnt_d;
   logic [7:0] tcmp_q, tcmp_d;
   logic [2:0] ctrl_q, ctrl_d;
   logic       stat_q, stat_d;

   logic       ram_hit;
   logic       ram_we;
   logic       timer_match;
   logic       hit;
   logic [7:0] rdata;

   assign ram_hit     = (bus.addr_in[6:5] == 2'b00);
   // A write presented while reset is asserted is dropped, RAM included.
   assign ram_we      = bus.we_in & ram_hit & ~rst_in;
   assign timer_match = ctrl_q[0] && (tcnt_q == tcmp_q);

   // ---------------- next-state logic ----------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      gpio_out_d = gpio_out_q;
      tcnt_d     = tcnt_q;
      tcmp_d     = tcmp_q;
      ctrl_d     = ctrl_q;
      stat_d     = stat_q;

      if (ctrl_q[0]) begin
         tcnt_d = (timer_match && ctrl_q[1]) ? 8'h00 : tcnt_q + 8'd1;
      end

      // Set beats a same-edge write-1-to-clear.
      if (timer_match) begin
         stat_d = 1'b1;
      end else if (bus.we_in && (bus.addr_in == ADDR_STAT) && bus.data_in[0]) begin
         stat_d = 1'b0;
      end

      // CPU writes come last so a TCNT write overrides count/reload.
      if (bus.we_in) begin
         case (bus.addr_in)
            ADDR_GPIO_OUT: gpio_out_d = bus.data_in;
            ADDR_TCNT:     tcnt_d     = bus.data_in;
            ADDR_TCMP:     tcmp_d     = bus.data_in;
            ADDR_CTRL:     ctrl_d     = bus.data_in[2:0];
            default:       ;
         endcase
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         gpio_out_q <= 8'h00;
         sync1_q    <= 8'h00;
         sync2_q    <= 8'h00;
         tcnt_q     <= 8'h00;
         tcmp_q     <= 8'h00;
         ctrl_q     <= 3'b000;
         stat_q     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
         gpio_out_q <= gpio_out_d;
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         tcnt_q     <= tcnt_d;
         tcmp_q     <= tcmp_d;
         ctrl_q     <= ctrl_d;
         stat_q     <= stat_d;
      end
   end

   // NOTE: the RAM array has no reset; its contents are undefined until written, which keeps it a plain memory.
   always_ff @(posedge clk_in) begin
      if (ram_we) begin
         ram_q[bus.addr_in[4:0]] <= bus.data_in;
      end
   end

   // ---------------- zero-wait-state read mux ----------------
   always_comb begin
      hit   = 1'b1;
      rdata = 8'h00;
      if (ram_hit) begin
         rdata = ram_q[bus.addr_in[4:0]];
      end else begin
         case (bus.addr_in)
            ADDR_GPIO_OUT: rdata = gpio_out_q;
            ADDR_GPIO_IN:  rdata = sync2_q;
            ADDR_TCNT:     rdata = tcnt_q;
            ADDR_TCMP:     rdata = tcmp_q;
            ADDR_CTRL:     rdata = {5'b00000, ctrl_q};
            ADDR_STAT:     rdata = {7'b0000000, stat_q};
            default:       hit   = 1'b0;
         endcase
      end
   end

   assign bus.data_oe  = hit & ~bus.we_in;
   assign bus.data_out = bus.data_oe ? rdata : 8'h00;

   assign gpio_out = gpio_out_q;
   assign irq_out  = stat_q & ctrl_q[2];

endmodule

// File: tb/tb_minibyte_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_minibyte_bus_responder
//   Directed scenarios followed by random bus traffic, all compared against
//   a behavioural model of the register map kept in this file.
// ---------------------------------------------------------------------------
module tb_minibyte_bus_responder;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out;
   logic       irq_out;

   minibyte_bus_responder_if bus ();

   minibyte_bus_responder dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .bus      (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .irq_out  (irq_out)
   );

   always #5 clk_in = ~clk_in;

   int total = 0;
   int bad   = 0;

   logic [7:0] gpio_drv = 8'h00;

   // ---------------- behavioural model ----------------
   logic [7:0] m_ram    [32];
   bit         m_ram_ok [32];
   logic [7:0] m_gpio_out, m_tcnt, m_tcmp, m_ctrl, m_s1, m_s2;
   bit         m_stat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_gpio_out = 8'h00;
      m_tcnt     = 8'h00;
      m_tcmp     = 8'h00;
      m_ctrl     = 8'h00;
      m_stat     = 1'b0;
      m_s1       = 8'h00;
      m_s2       = 8'h00;
      for (int i = 0; i < 32; i++) m_ram_ok[i] = 1'b0;
   endfunction

   function automatic void model_read(input logic [6:0] a, input logic we,
                                      output logic oe, output logic [7:0] d, output bit known);
      oe    = 1'b0;
      d     = 8'h00;
      known = 1'b1;
      if (!we) begin
         if (a < 7'd32) begin
            oe    = 1'b1;
            d     = m_ram[a[4:0]];
            known = m_ram_ok[a[4:0]];
         end else begin
            oe = 1'b1;
            case (a)
               7'h60:   d = m_gpio_out;
               7'h61:   d = m_s2;
               7'h62:   d = m_tcnt;
               7'h63:   d = m_tcmp;
               7'h64:   d = m_ctrl;
               7'h65:   d = {7'd0, m_stat};
               default: oe = 1'b0;
            endcase
         end
      end
   endfunction

   // One rising edge of the register map, from its textual rules.
   function automatic void model_edge(input logic [6:0] a, input logic we,
                                      input logic [7:0] d, input logic [7:0] gin);
      bit         enabled = m_ctrl[0];
      bit         match   = enabled && (m_tcnt == m_tcmp);
      logic [7:0] cnt     = m_tcnt;
      bit         st      = m_stat;
      if (enabled) cnt = (match && m_ctrl[1]) ? 8'd0 : (m_tcnt + 8'd1) % 256;
      if (match) st = 1'b1;
      else if (we && a == 7'h65 && d[0]) st = 1'b0;
      if (we) begin
         if (a < 7'd32) begin
            m_ram[a[4:0]]    = d;
            m_ram_ok[a[4:0]] = 1'b1;
         end
         if (a == 7'h60) m_gpio_out = d;
         if (a == 7'h62) cnt = d;
         if (a == 7'h63) m_tcmp = d;
         if (a == 7'h64) m_ctrl = d & 8'h07;
      end
      m_tcnt = cnt;
      m_stat = st;
      m_s2   = m_s1;
      m_s1   = gin;
   endfunction

   // ---------------- bus helpers ----------------
   task automatic drive_and_compare(input logic [6:0] a, input logic we, input logic [7:0] d);
      logic       e_oe;
      logic [7:0] e_d;
      bit         known;
      @(negedge clk_in);
      bus.addr_in = a;
      bus.we_in   = we;
      bus.data_in = d;
      gpio_in     = gpio_drv;
      #1;
      model_read(a, we, e_oe, e_d, known);
      check("oe", bus.data_oe, e_oe);
      if (known) check("rdata", bus.data_out, e_d);
      check("gpio_out", gpio_out, m_gpio_out);
      check("irq", irq_out, m_stat & m_ctrl[2]);
   endtask

   task automatic finish_edge(input logic [6:0] a, input logic we, input logic [7:0] d);
      @(posedge clk_in);
      model_edge(a, we, d, gpio_in);
      #1;
   endtask

   task automatic cycle(input logic [6:0] a, input logic we, input logic [7:0] d);
      drive_and_compare(a, we, d);
      finish_edge(a, we, d);
   endtask

   task automatic rd(input logic [6:0] a, input logic [7:0] exp_d, input logic exp_oe, input string tag);
      drive_and_compare(a, 1'b0, 8'h00);
      check(tag, bus.data_out, exp_d);
      check({tag, "_oe"}, bus.data_oe, exp_oe);
      finish_edge(a, 1'b0, 8'h00);
   endtask

   // Reads every register while rst_in is held, expecting all zero.
   task automatic reset_reads(input string tag);
      check({tag, "_gpio_out"}, gpio_out, 8'h00);
      check({tag, "_irq"}, irq_out, 1'b0);
      bus.we_in = 1'b0;
      for (int r = 'h60; r <= 'h65; r++) begin
         bus.addr_in = 7'(r);
         #1;
         check($sformatf("%s_reg%0h", tag, r), bus.data_out, 8'h00);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      rst_in      = 1'b1;
      bus.addr_in = 7'h00;
      bus.we_in   = 1'b0;
      bus.data_in = 8'h00;
      gpio_in     = 8'h00;
      model_reset();
      #2;
      reset_reads("por");
      @(negedge clk_in);
      rst_in = 1'b0;

      // RAM
      cycle(7'h1F, 1'b1, 8'hA5);
      cycle(7'h00, 1'b1, 8'h3C);
      rd(7'h1F, 8'hA5, 1'b1, "ram_1f");
      rd(7'h00, 8'h3C, 1'b1, "ram_00");
      rd(7'h20, 8'h00, 1'b0, "miss_20");

      // GPIO
      cycle(7'h60, 1'b1, 8'h81);
      check("gpio_out_81", gpio_out, 8'h81);
      gpio_drv = 8'h5A;
      cycle(7'h00, 1'b0, 8'h00);
      rd(7'h61, 8'h00, 1'b1, "gpio_in_1edge");
      rd(7'h61, 8'h5A, 1'b1, "gpio_in_2edge");

      // Auto-reload
      cycle(7'h62, 1'b1, 8'h00);
      cycle(7'h63, 1'b1, 8'h03);
      cycle(7'h64, 1'b1, 8'h07);
      rd(7'h62, 8'h00, 1'b1, "ar_cnt0");
      rd(7'h62, 8'h01, 1'b1, "ar_cnt1");
      rd(7'h62, 8'h02, 1'b1, "ar_cnt2");
      rd(7'h62, 8'h03, 1'b1, "ar_cnt3");
      rd(7'h62, 8'h00, 1'b1, "ar_reload");
      check("ar_irq_set", irq_out, 1'b1);
      rd(7'h65, 8'h01, 1'b1, "ar_stat");
      cycle(7'h65, 1'b1, 8'h01);
      check("ar_irq_clr", irq_out, 1'b0);

      // Collision: TCNT write on a match/reload edge wins
      cycle(7'h62, 1'b1, 8'h10);
      rd(7'h62, 8'h10, 1'b1, "tcnt_write_wins");

      // Collision: W1C on the match edge keeps the flag
      cycle(7'h64, 1'b1, 8'h00);
      cycle(7'h65, 1'b1, 8'h01);
      rd(7'h65, 8'h00, 1'b1, "stat_cleared");
      cycle(7'h63, 1'b1, 8'h20);
      cycle(7'h62, 1'b1, 8'h1E);
      cycle(7'h64, 1'b1, 8'h01);
      rd(7'h62, 8'h1E, 1'b1, "w1c_cnt1e");
      rd(7'h62, 8'h1F, 1'b1, "w1c_cnt1f");
      cycle(7'h65, 1'b1, 8'h01);
      rd(7'h65, 8'h01, 1'b1, "w1c_set_wins");

      // Free-run wrap without side effects, then match at 0x80
      cycle(7'h64, 1'b1, 8'h00);
      cycle(7'h65, 1'b1, 8'h01);
      cycle(7'h63, 1'b1, 8'h80);
      cycle(7'h62, 1'b1, 8'hFE);
      cycle(7'h64, 1'b1, 8'h01);
      rd(7'h62, 8'hFE, 1'b1, "fr_fe");
      rd(7'h62, 8'hFF, 1'b1, "fr_ff");
      rd(7'h62, 8'h00, 1'b1, "fr_wrap");
      rd(7'h65, 8'h00, 1'b1, "fr_no_flag");
      for (int i = 0; i < 126; i++) cycle(7'h65, 1'b0, 8'h00);
      rd(7'h62, 8'h80, 1'b1, "fr_at_80");
      rd(7'h65, 8'h01, 1'b1, "fr_flag_80");
      rd(7'h1F, 8'hA5, 1'b1, "ram_kept");

      // Reset between edges with the timer running and a write in flight
      cycle(7'h64, 1'b1, 8'h07);
      check("irq_pre_reset", irq_out, 1'b1);
      @(negedge clk_in);
      bus.addr_in = 7'h60;
      bus.we_in   = 1'b1;
      bus.data_in = 8'hFF;
      #2;
      rst_in = 1'b1;
      #1;
      check("rst_gpio_now", gpio_out, 8'h00);
      check("rst_irq_now", irq_out, 1'b0);
      @(posedge clk_in);
      #1;
      model_reset();
      reset_reads("rst");
      @(negedge clk_in);
      rst_in      = 1'b0;
      bus.addr_in = 7'h60;
      bus.we_in   = 1'b1;
      bus.data_in = 8'h3C;
      gpio_in     = gpio_drv;
      finish_edge(7'h60, 1'b1, 8'h3C);
      check("post_rst_write", gpio_out, 8'h3C);
      rd(7'h60, 8'h3C, 1'b1, "post_rst_read");

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [6:0] a;
         int         sel;
         sel = $urandom_range(0, 9);
         if (sel < 5)      a = 7'($urandom_range(0, 31));
         else if (sel < 8) a = 7'($urandom_range('h60, 'h65));
         else if (sel < 9) a = 7'($urandom_range('h20, 'h5F));
         else              a = 7'($urandom_range('h66, 'h7F));
         gpio_drv = 8'($urandom_range(0, 255));
         cycle(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/minibyte_bus_responder.md
MINIBYTE_BUS_RESPONDER -- requirements
Module: minibyte_bus_responder

Interface
REQ-001 SHALL have these ports:
- clk_in  in  1  system clock; all state updates on the rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- addr_in  in  7  CPU address bus.
- we_in  in  1  CPU write enable; 1 = write cycle.
- data_in  in  8  CPU write data.
- data_out  out  8  read data returned to the CPU.
- data_oe  out  1  data_out valid/drive enable.
- gpio_in  in  8  asynchronous external inputs.
- gpio_out  out  8  general-purpose output register.
- irq_out  out  1  timer interrupt request.
REQ-002 SHALL use one clock (clk_in) with asynchronous active-high reset (rst_in).

Function
REQ-003 SHALL respond to this address map; every other address is a miss:
- 0x00-0x1F: 32x8 RAM, read/write.
- 0x60: GPIO_OUT, read/write.
- 0x61: GPIO_IN, read-only; returns the 2-flop-synchronized gpio_in.
- 0x62: TCNT, timer count, read/write.
- 0x63: TCMP, timer compare value, read/write.
- 0x64: CTRL, read/write; bit0 = timer enable, bit1 = auto-reload, bit2 = irq enable, bits7:3 read 0.
- 0x65: STAT, bit0 = match flag; write-1-to-clear; bits7:1 read 0.
REQ-004 SHALL commit a write on the rising edge where we_in=1 and the address hits a writable location. Writes to read-only locations and to misses SHALL be ignored.
REQ-005 SHALL make reads zero-wait-state: data_out is combinational from addr_in and the current register state. data_oe SHALL be 1 iff we_in=0 and the address hits.
REQ-006 SHALL drive data_out=0x00 whenever data_oe=0.
REQ-007 SHALL return read-after-write data (new value) on the cycle after the write edge.
REQ-008 gpio_out SHALL equal the GPIO_OUT register directly.
REQ-009 The GPIO_IN read value SHALL lag gpio_in by exactly 2 clk_in edges.
REQ-010 When CTRL.bit0=1, TCNT SHALL increment by 1 modulo 256 on each edge.
REQ-011 On an edge where TCNT==TCMP and CTRL.bit0=1:
- STAT.bit0 SHALL set.
- If CTRL.bit1=1, TCNT SHALL load 0x00 instead of incrementing.
REQ-012 When CTRL.bit1=0, TCNT SHALL wrap 0xFF->0x00 with no side effect other than REQ-011.
REQ-013 A CPU write to TCNT on the same edge as an increment or reload SHALL take priority.
REQ-014 A write-1-to-clear of STAT.bit0 on the same edge as a new match SHALL leave STAT.bit0=1 (set wins).
REQ-015 When CTRL.bit0=0, TCNT SHALL hold and no matches SHALL occur.
REQ-016 irq_out SHALL be registered-state-derived: STAT.bit0 AND CTRL.bit2, with no combinational path from the bus inputs.
REQ-017 RAM SHALL be 32 entries indexed by addr_in[4:0], and its contents SHALL be preserved across timer activity.

Reset
REQ-018 rst_in=1 SHALL immediately, without waiting for a clock edge, clear:
- GPIO_OUT, TCNT, TCMP, CTRL, STAT and both synchronizer stages to 0x00;
- gpio_out=0x00 and irq_out=0.
REQ-019 RAM contents SHALL be unspecified after reset; the bench SHALL NOT check them before writing.
REQ-020 Assertion of rst_in mid-count or mid-write SHALL discard the in-flight write. The first legal write SHALL be accepted on the first rising edge after deassertion.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios:
- RAM: write 0xA5 to 0x1F, then 0x3C to 0x00; read both -> 0xA5 and 0x3C with data_oe=1. Read 0x20 -> data_oe=0, data_out=0x00.
- GPIO: write 0x81 to 0x60 -> gpio_out=0x81 next cycle. Drive gpio_in=0x5A -> reading 0x61 returns 0x5A from the 2nd edge onward.
- Auto-reload: TCMP=0x03, CTRL=0x07 with TCNT=0 -> TCNT counts 0,1,2,3,0 and STAT.bit0=1 with irq_out=1 after the match edge. Write 0x01 to 0x65 -> irq_out=0.
- Collisions: write 0x10 to TCNT on the same edge as an increment -> TCNT=0x10. W1C on the match edge -> STAT.bit0 stays 1.
- Free-run: CTRL=0x01, TCMP=0x80, TCNT=0xFE -> TCNT goes 0xFF, 0x00 with no flag set. STAT sets only when TCNT reaches 0x80.
- Reset: assert rst_in between clock edges while CTRL=0x07 -> all registers and outputs read 0 immediately. A post-reset write to 0x60 takes effect.
